// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock, signed/unsigned per op.
// Optional early termination on all-zero remaining digits via `define BOOTH_ZERO_SKIP_EN.
module booth_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic               ack_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] result_o
);
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int CW   = $clog2(NDIG);
  localparam int PW   = 2 * WIDTH;
  localparam int BW   = WIDTH + 3;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_seq_mul: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;      // multiplicand, pre-shifted by 2i
  logic [BW-1:0]   b_q, b_d;      // extended multiplier; b_q[2:0] is the current triplet
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_sum;
  logic            skip;
  logic            last;
  logic            sa, sb;

  assign sa = signed_i & multiplicand_i[WIDTH-1];
  assign sb = signed_i & multiplier_i[WIDTH-1];

  always_comb begin
    pp = '0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  assign acc_sum = acc_q + pp;

`ifdef BOOTH_ZERO_SKIP_EN
  // Remaining bits all equal means every later triplet is 000 or 111.
  logic [WIDTH:0] rem;
  assign rem  = b_q[BW-1:2];
  assign skip = (rem == '0) || (rem == '1);
`else
  assign skip = 1'b0;
`endif

  assign last = (state_q == S_CALC) && ((cnt_q == CW'(NDIG - 1)) || skip);

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CALC;
      S_CALC:  if (last)    state_d = S_DONE;
      S_DONE:  if (ack_i)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_o = (state_q == S_IDLE);
    valid_o = (state_q == S_DONE);
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        a_d   = {{WIDTH{sa}}, multiplicand_i};
        b_d   = {sb, sb, multiplier_i, 1'b0};
        acc_d = '0;
        cnt_d = '0;
      end
      S_CALC: begin
        a_d   = a_q << 2;
        b_d   = {b_q[BW-1], b_q[BW-1], b_q[BW-1:2]};
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (last) res_d = acc_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul (WIDTH=8): directed vector table, handshake/reset corners, random ops vs arithmetic model.
module tb_booth_seq_mul;
  localparam int W    = 8;
  localparam int NDIG = W / 2 + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, sgn, ack;
  logic [W-1:0]    a, b;
  logic            ready, valid;
  logic [2*W-1:0]  result;

  int pass_cnt = 0;
  int total    = 0;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
    .multiplicand_i(a), .multiplier_i(b), .ack_i(ack),
    .ready_o(ready), .valid_o(valid), .result_o(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint xv, yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return (2*W)'(xv * yv);
  endfunction

  function automatic int exp_lat(input bit s, input logic [W-1:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
    logic [W+1:0] bx;
    bit same;
    bx = {s & y[W-1], s & y[W-1], y};
    for (int i = 0; i < NDIG; i++) begin
      same = 1'b1;
      for (int j = 2*i + 1; j <= W + 1; j++)
        if (bx[j] != bx[2*i+1]) same = 1'b0;
      if (same) return i + 1;
    end
    return NDIG;
`else
    if (s && y == '1) return NDIG;
    return NDIG;
`endif
  endfunction

  // One operation. start stays high through CALC/DONE and inputs are scrambled while busy,
  // so a re-accept or late sampling of signed_i/operands shows up as a wrong result.
  task automatic do_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, output logic [2*W-1:0] res, output int lat);
    chk("ready_before_start", 32'(ready), 32'd1);
    sgn = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    res = '0;
    while (1) begin
      sgn = ~sgn; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      lat++;
      if (valid) break;
      chk("ready_low_in_calc", 32'(ready), 32'd0);
      if (lat > 50) begin
        chk("valid_timeout", 32'(valid), 32'd1);
        break;
      end
    end
    res = result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_result", 32'(result), 32'(res));
      chk("hold_ready", 32'(ready), 32'd0);
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    start = 1'b0;
    chk("idle_after_ack", 32'(ready), 32'd1);
    chk("valid_drop_after_ack", 32'(valid), 32'd0);
    chk("result_held_in_idle", 32'(result), 32'(res));
  endtask

  vec_t tv[9];

  initial begin
    logic [2*W-1:0] r;
    int lat;
    logic [W-1:0] rx, ry;
    bit rs;

    tv[0] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    tv[1] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    tv[2] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
    tv[3] = '{1'b0, 8'd200, 8'd3,   16'h0258};
    tv[4] = '{1'b1, 8'd200, 8'd3,   16'hFF58};
    tv[5] = '{1'b0, 8'd5,   8'd3,   16'h000F};
    tv[6] = '{1'b0, 8'd77,  8'd0,   16'h0000};
    tv[7] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    tv[8] = '{1'b1, 8'h7F,  8'hFF,  16'hFF81};

    rst = 1'b1; start = 1'b0; sgn = 1'b0; ack = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_mul(tv[i].s, tv[i].a, tv[i].b, (i == 0) ? 10 : 0, r, lat);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(tv[i].p));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(tv[i].s, tv[i].b)));
    end

    // Asynchronous reset two CALC cycles into an operation.
    sgn = 1'b0; a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_mul(1'b0, 8'd7, 8'd9, 0, r, lat);
    chk("post_rst_7x9", 32'(r), 32'h003F);
    chk("post_rst_lat", 32'(lat), 32'(exp_lat(1'b0, 8'd9)));

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom);
      rx = W'($urandom);
      ry = W'($urandom);
      do_mul(rs, rx, ry, n % 3, r, lat);
      chk($sformatf("rand%0d_s%0d_%0h_x_%0h", n, rs, rx, ry), 32'(r), 32'(ref_mul(rs, rx, ry)));
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat(rs, ry)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total);
    $fatal(1, "timeout");
  end
endmodule
